// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the memory arbiter: FSM state encoding,
// bus width defaults and the wait-counter sizing helper.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  localparam int ADDR_W_DEF  = 4;
  localparam int DATA_W_DEF  = 32;
  localparam int TIMEOUT_DEF = 8;

  // Wait counter is never narrower than 4 bits, even for tiny timeouts.
  function automatic int cnt_width(input int timeout);
    int w;
    w = $clog2(timeout);
    if (w > 4) begin
      return w;
    end else begin
      return 4;
    end
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Round-robin picker: scans requests starting one above the last grant,
// wrapping around, and reports the first pending index.
module rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [IDX_W-1:0]   grant,
  output logic               any_req
);

  logic [IDX_W-1:0] idx_s;

  // First pending requester at or after last_grant+1, modulo NUM_REQ.
  always_comb begin
    grant   = {IDX_W{1'b0}};
    any_req = 1'b0;
    idx_s   = {IDX_W{1'b0}};
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx_s   = IDX_W'((int'(last_grant) + i) % NUM_REQ);
      grant   = (!any_req && req[idx_s]) ? idx_s : grant;
      any_req = any_req | req[idx_s];
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Multi-requester single-port memory arbiter: round-robin grant, one
// outstanding memory access, bounded wait with timeout error response.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      mem_en,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata,
  input  logic                      mem_valid
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = cnt_width(TIMEOUT);
  localparam logic [IDX_W-1:0]   LAST_RST = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  arb_state_e         state_r, state_s;
  logic [IDX_W-1:0]   grant_r, last_grant_r, last_grant_s, pick_s;
  logic               any_s, take_s, timeout_s, we_r;
  logic [ADDR_W-1:0]  addr_r;
  logic [DATA_W-1:0]  wdata_r;
  logic [CNT_W-1:0]   cnt_r, cnt_s;

  logic [NUM_REQ-1:0] req_ready_s, rsp_valid_s;
  logic [DATA_W-1:0]  rsp_rdata_s, mem_wdata_s;
  logic               rsp_err_s, mem_en_s;
  logic [ADDR_W-1:0]  mem_addr_s;

  logic [ADDR_W-1:0]  addr_arr_s  [NUM_REQ];
  logic [DATA_W-1:0]  wdata_arr_s [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr_s[g]  = req_addr[g*ADDR_W +: ADDR_W];
    assign wdata_arr_s[g] = req_wdata[g*DATA_W +: DATA_W];
  end

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req        (req_valid),
    .last_grant (last_grant_r),
    .grant      (pick_s),
    .any_req    (any_s)
  );

  assign timeout_s = (cnt_r == CNT_LAST);

  // State, latched request and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      grant_r      <= {IDX_W{1'b0}};
      last_grant_r <= LAST_RST;
      we_r         <= 1'b0;
      addr_r       <= {ADDR_W{1'b0}};
      wdata_r      <= {DATA_W{1'b0}};
      cnt_r        <= {CNT_W{1'b0}};
      req_ready    <= {NUM_REQ{1'b0}};
      rsp_valid    <= {NUM_REQ{1'b0}};
      rsp_rdata    <= {DATA_W{1'b0}};
      rsp_err      <= 1'b0;
      mem_en       <= 1'b0;
      mem_addr     <= {ADDR_W{1'b0}};
      mem_wdata    <= {DATA_W{1'b0}};
    end else begin
      state_r      <= state_s;
      last_grant_r <= last_grant_s;
      cnt_r        <= cnt_s;
      req_ready    <= req_ready_s;
      rsp_valid    <= rsp_valid_s;
      rsp_rdata    <= rsp_rdata_s;
      rsp_err      <= rsp_err_s;
      mem_en       <= mem_en_s;
      mem_addr     <= mem_addr_s;
      mem_wdata    <= mem_wdata_s;
      if (take_s) begin
        grant_r <= pick_s;
        we_r    <= req_we[pick_s];
        addr_r  <= addr_arr_s[pick_s];
        wdata_r <= wdata_arr_s[pick_s];
      end
    end
  end

  // Next-state logic; mem_valid beats the timeout when both occur.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    state_s = any_s ? ISSUE : IDLE;
      ISSUE:   state_s = WAIT;
      WAIT:    state_s = (mem_valid || timeout_s) ? RESP : WAIT;
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Next values of the registered outputs and bookkeeping registers.
  always_comb begin
    take_s       = 1'b0;
    req_ready_s  = {NUM_REQ{1'b0}};
    rsp_valid_s  = {NUM_REQ{1'b0}};
    rsp_rdata_s  = rsp_rdata;
    rsp_err_s    = rsp_err;
    mem_en_s     = 1'b0;
    mem_addr_s   = mem_addr;
    mem_wdata_s  = mem_wdata;
    cnt_s        = cnt_r;
    last_grant_s = last_grant_r;
    case (state_r)
      IDLE: begin
        if (any_s) begin
          take_s      = 1'b1;
          req_ready_s = ONE_HOT0 << pick_s;
        end else begin
          take_s      = 1'b0;
        end
      end
      ISSUE: begin
        mem_en_s    = we_r;
        mem_addr_s  = addr_r;
        mem_wdata_s = wdata_r;
        cnt_s       = {CNT_W{1'b0}};
      end
      WAIT: begin
        if (mem_valid) begin
          rsp_valid_s = ONE_HOT0 << grant_r;
          rsp_rdata_s = we_r ? {DATA_W{1'b0}} : mem_rdata;
          rsp_err_s   = 1'b0;
        end else if (timeout_s) begin
          rsp_valid_s = ONE_HOT0 << grant_r;
          rsp_rdata_s = {DATA_W{1'b0}};
          rsp_err_s   = 1'b1;
        end else begin
          cnt_s       = cnt_r + CNT_W'(1);
        end
      end
      RESP: begin
        last_grant_s = grant_r;
      end
      default: begin
        take_s = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, reset-mid-wait
// sequence and randomized transactions against a behavioural model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_ready, req_we, rsp_valid;
  logic [7:0]  req_addr;
  logic [63:0] req_wdata;
  logic [31:0] rsp_rdata, mem_wdata, mem_rdata;
  logic        rsp_err, mem_en, mem_valid;
  logic [3:0]  mem_addr;

  int n_vec = 0;
  int n_bad = 0;
  int last_m;
  logic [31:0] mem_m [16];

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .mem_en    (mem_en),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_valid (mem_valid)
  );

  typedef struct {
    logic [1:0]  mask;
    logic [1:0]  we;
    logic [3:0]  a0, a1;
    logic [31:0] w0, w1;
    int          dly;     // WAIT cycle carrying mem_valid; 99 = never
    logic [31:0] mdata;
    int          g;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t tv [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] onehot(input int g);
    return (g == 1) ? 2'b10 : 2'b01;
  endfunction

  // Two-requester round robin: a lone request wins, a tie goes to the one not served last.
  function automatic int rr_model(input logic [1:0] m, input int last);
    if (m == 2'b11) return 1 - last;
    else if (m[1]) return 1;
    else return 0;
  endfunction

  task automatic wait_accept(input int g);
    int n;
    n = 0;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      if (req_ready != 2'b00) begin
        n = c;
        break;
      end
    end
    chk("ready_latency", 64'(n), 64'd1);
    chk("ready_onehot", 64'(req_ready), 64'(onehot(g)));
  endtask

  task automatic finish_txn(input int g, input logic we, input logic [3:0] addr,
                            input logic [31:0] wd, input int d, input logic [31:0] mdata,
                            input logic [31:0] exp_rd, input logic exp_err);
    int  rk, ek;
    bit  got;
    ek = (d <= 7) ? d : 7;
    // spurious completion during ISSUE must be ignored
    mem_valid = 1'b1;
    mem_rdata = $urandom();
    chk("mem_en_before", 64'(mem_en), 64'd0);
    @(posedge clk); #1;
    chk("mem_en_drive", 64'(mem_en), 64'(we));
    chk("mem_addr", 64'(mem_addr), 64'(addr));
    chk("mem_wdata", 64'(mem_wdata), 64'(wd));
    got = 1'b0;
    rk  = -1;
    for (int k = 0; k < 12; k++) begin
      mem_valid = (k == d);
      mem_rdata = (k == d) ? mdata : $urandom();
      @(posedge clk); #1;
      if (k == 0) chk("mem_en_one_cycle", 64'(mem_en), 64'd0);
      if (rsp_valid != 2'b00) begin
        got = 1'b1;
        rk  = k;
        break;
      end
    end
    chk("rsp_seen", 64'(got), 64'd1);
    chk("rsp_cycle", 64'(rk), 64'(ek));
    chk("rsp_valid", 64'(rsp_valid), 64'(onehot(g)));
    chk("rsp_rdata", 64'(rsp_rdata), 64'(exp_rd));
    chk("rsp_err", 64'(rsp_err), 64'(exp_err));
    mem_valid = 1'b1;
    mem_rdata = $urandom();
    @(posedge clk); #1;
    mem_valid = 1'b0;
    chk("rsp_one_cycle", 64'(rsp_valid), 64'd0);
    chk("ready_idle", 64'(req_ready), 64'd0);
  endtask

  // Model-driven transaction; bench memory mem_m supplies read data.
  task automatic do_txn(input logic [1:0] m, input logic [1:0] we, input logic [3:0] a0,
                        input logic [3:0] a1, input logic [31:0] w0, input logic [31:0] w1,
                        input int d);
    int g;
    logic        wg;
    logic [3:0]  ag;
    logic [31:0] wdg, md, erd;
    req_we    = we;
    req_addr  = {a1, a0};
    req_wdata = {w1, w0};
    req_valid = m;
    if (m == 2'b00) begin
      repeat (3) begin
        @(posedge clk); #1;
        chk("no_req_ready", 64'(req_ready), 64'd0);
        chk("no_req_rsp", 64'(rsp_valid), 64'd0);
      end
    end else begin
      g   = rr_model(m, last_m);
      wg  = (g == 1) ? we[1] : we[0];
      ag  = (g == 1) ? a1 : a0;
      wdg = (g == 1) ? w1 : w0;
      md  = wg ? $urandom() : mem_m[ag];
      erd = (wg || d == 99) ? 32'h0 : mem_m[ag];
      wait_accept(g);
      finish_txn(g, wg, ag, wdg, d, md, erd, d == 99);
      last_m = g;
      if (wg && d != 99) mem_m[ag] = wdg;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int r, dd;
    rst = 1'b1; req_valid = 2'b00; req_we = 2'b00; req_addr = 8'h00;
    req_wdata = 64'h0; mem_rdata = 32'h0; mem_valid = 1'b0;
    for (int i = 0; i < 16; i++) mem_m[i] = $urandom();

    tv[0] = '{2'b11, 2'b11, 4'h1, 4'h2, 32'hA0A0A0A0, 32'hB1B1B1B1, 1,  32'h12345678, 0, 32'h0,        1'b0};
    tv[1] = '{2'b11, 2'b11, 4'h1, 4'h2, 32'hA0A0A0A0, 32'hB1B1B1B1, 2,  32'h12345678, 1, 32'h0,        1'b0};
    tv[2] = '{2'b11, 2'b00, 4'h4, 4'h5, 32'h0,        32'h0,        3,  32'hCAFEF00D, 0, 32'hCAFEF00D, 1'b0};
    tv[3] = '{2'b11, 2'b00, 4'h4, 4'h5, 32'h0,        32'h0,        2,  32'h0BADC0DE, 1, 32'h0BADC0DE, 1'b0};
    tv[4] = '{2'b01, 2'b01, 4'h3, 4'h0, 32'hDEADBEEF, 32'h0,        1,  32'h55555555, 0, 32'h0,        1'b0};
    tv[5] = '{2'b10, 2'b00, 4'h0, 4'h3, 32'h0,        32'h0,        1,  32'hDEADBEEF, 1, 32'hDEADBEEF, 1'b0};
    tv[6] = '{2'b01, 2'b00, 4'h7, 4'h0, 32'h0,        32'h0,        99, 32'h0,        0, 32'h0,        1'b1};
    tv[7] = '{2'b10, 2'b00, 4'h0, 4'h3, 32'h0,        32'h0,        7,  32'hDEADBEEF, 1, 32'hDEADBEEF, 1'b0};
    tv[8] = '{2'b01, 2'b01, 4'h9, 4'h0, 32'h11223344, 32'h0,        99, 32'h0,        0, 32'h0,        1'b1};
    tv[9] = '{2'b10, 2'b00, 4'h0, 4'hE, 32'h0,        32'h0,        6,  32'h76543210, 1, 32'h76543210, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    chk("rst_mem_en", 64'(mem_en), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      req_we    = tv[i].we;
      req_addr  = {tv[i].a1, tv[i].a0};
      req_wdata = {tv[i].w1, tv[i].w0};
      req_valid = tv[i].mask;
      wait_accept(tv[i].g);
      finish_txn(tv[i].g, (tv[i].g == 1) ? tv[i].we[1] : tv[i].we[0],
                 (tv[i].g == 1) ? tv[i].a1 : tv[i].a0,
                 (tv[i].g == 1) ? tv[i].w1 : tv[i].w0,
                 tv[i].dly, tv[i].mdata, tv[i].exp_rd, tv[i].exp_err);
    end
    last_m = 1;

    // Reset in the middle of WAIT: no response, reset outputs, priority back to requester 0.
    do_txn(2'b01, 2'b01, 4'h6, 4'h0, 32'h600DF00D, 32'h0, 2);
    req_we    = 2'b00;
    req_addr  = {4'h9, 4'hA};
    req_wdata = {32'h99999999, 32'hAAAAAAAA};
    req_valid = 2'b11;
    wait_accept(1);
    mem_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_req_ready", 64'(req_ready), 64'd0);
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("midrst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("midrst_rsp_err", 64'(rsp_err), 64'd0);
    chk("midrst_mem_en", 64'(mem_en), 64'd0);
    chk("midrst_mem_addr", 64'(mem_addr), 64'd0);
    chk("midrst_mem_wdata", 64'(mem_wdata), 64'd0);
    wait_accept(0);
    finish_txn(0, 1'b0, 4'hA, 32'hAAAAAAAA, 2, 32'h13572468, 32'h13572468, 1'b0);
    last_m = 0;

    for (int t = 0; t < 150; t++) begin
      r  = $urandom_range(1, 9);
      dd = (r >= 8) ? 99 : r;
      do_txn(2'($urandom_range(0, 3)), 2'($urandom()), 4'($urandom()), 4'($urandom()),
             $urandom(), $urandom(), dd);
    end
    req_valid = 2'b00;
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: NUM_REQ, default 2, number of requesters; ADDR_W, default 4, memory address width; DATA_W, default 32, memory data width; TIMEOUT, default 8, maximum WAIT cycles before an error response.
REQ-002 One clock; reset is synchronous and active-high. The ports are clk and rst.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 req_valid  in  NUM_REQ  per-requester request pending.
REQ-006 req_ready  out  NUM_REQ  one-hot accept pulse; a request transfers when valid&ready.
REQ-007 req_we  in  NUM_REQ  1=write, 0=read, per requester.
REQ-008 req_addr  in  NUM_REQ*ADDR_W  packed per-requester address.
REQ-009 req_wdata  in  NUM_REQ*DATA_W  packed per-requester write data.
REQ-010 rsp_valid  out  NUM_REQ  one-hot one-cycle response strobe.
REQ-011 rsp_rdata  out  DATA_W  read data, or 0 for writes and errors.
REQ-012 rsp_err  out  1  timeout flag, qualified by rsp_valid.
REQ-013 mem_en  out  1  memory write enable (1=write, 0=read).
REQ-014 mem_addr  out  ADDR_W  memory address.
REQ-015 mem_wdata  out  DATA_W  memory write data.
REQ-016 mem_rdata  in  DATA_W  memory read data.
REQ-017 mem_valid  in  1  memory completion.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT, RESP.
REQ-019 IDLE: if any req_valid is set, the block SHALL select a winner round-robin, pulse req_ready[winner] for one cycle, latch we/addr/wdata and the grant index, and move to ISSUE; otherwise it stays in IDLE.
REQ-020 Round-robin priority SHALL start at (last_grant+1) mod NUM_REQ and proceed upward with wrap; after reset, last_grant=NUM_REQ-1, so requester 0 has first priority.
REQ-021 ISSUE: the block SHALL drive mem_en/mem_addr/mem_wdata from the latched request for exactly one cycle, then go to WAIT.
REQ-022 Outside ISSUE, the block SHALL hold mem_en=0, keep mem_addr at the last value, and keep mem_wdata at the last value.
REQ-023 WAIT: a 4-bit-wide-minimum cycle counter SHALL start at 0; on mem_valid=1 the block SHALL capture mem_rdata (read) or 0 (write), set err=0, and go to RESP.
REQ-024 WAIT: when the counter reaches TIMEOUT-1 without mem_valid, the block SHALL set err=1 and rdata=0, and go to RESP.
REQ-025 If mem_valid and timeout occur in the same cycle, mem_valid SHALL win (err=0).
REQ-026 mem_valid SHALL be ignored in IDLE, ISSUE and RESP.
REQ-027 RESP: the block SHALL assert rsp_valid[grant] for one cycle with the registered rsp_rdata/rsp_err, update last_grant=grant, and return to IDLE.
REQ-028 Minimum latency: accept at cycle T, mem drive at T+1, mem_valid earliest at T+2, rsp_valid at T+3; throughput is at most one transaction per 4 cycles.
REQ-029 At most one requester SHALL be granted per transaction; ungranted requests stay pending, without req_ready, until won.
REQ-030 A requester dropping req_valid while ungranted SHALL be legal and SHALL NOT produce a response.
REQ-031 All outputs SHALL be registered.

Reset
REQ-032 When rst=1 at a rising edge, the block SHALL enter IDLE from any state, abandoning any in-flight transaction without a response.
REQ-033 Reset values SHALL be: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_en=0, mem_addr=0, mem_wdata=0, counter=0, last_grant=NUM_REQ-1.

Structure
REQ-034 The state enum (arb_state_e: IDLE, ISSUE, WAIT, RESP), the ADDR_W/DATA_W defaults and the TIMEOUT default SHALL live in the shared project package.
REQ-035 The round-robin selection SHALL be a sub-module rr_picker (inputs req vector and last_grant; outputs grant index and any_req).

Verification
REQ-036 Single write: req0 we=1 addr=3 wdata=0xDEADBEEF, mem_valid at T+2 -> mem_en=1 at T+1, rsp_valid=01 at T+3, rdata=0, err=0.
REQ-037 Read after write: req1 read addr=3, memory returns 0xDEADBEEF -> rsp_valid=10, rsp_rdata=0xDEADBEEF.
REQ-038 Contention: req0 and req1 held valid for 4 transactions -> grants alternate 0,1,0,1, with requester 0 first after reset.
REQ-039 Timeout: mem_valid never asserted -> rsp_err=1 and rsp_rdata=0 at 8 WAIT cycles, then IDLE.
REQ-040 Late valid: mem_valid exactly on the final WAIT cycle -> err=0 and data captured.
REQ-041 Reset mid-WAIT: rst pulse -> no rsp_valid, all outputs at reset values next cycle, and the next grant goes to requester 0.
